// File: rtl/branch_predictor.sv
// Fetch-side gshare predictor: 2-bit PHT indexed by PC ^ GHR plus a direct-mapped BTB.
// Optional statistics counters are generated only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          F_PC,
  output logic                 F_pred_taken,
  output logic [PHT_IDX_W-1:0] F_pht_idx,
  output logic                 F_btb_hit,
  output logic [31:0]          F_btb_target,
  output logic [31:0]          F_next_pc,
  input  logic                 ex_update_en,
  input  logic                 ex_actual_taken,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_actual_target,
  input  logic [PHT_IDX_W-1:0] ex_pht_idx,
  input  logic                 redirect_valid,
  output logic [31:0]          stat_updates,
  output logic [31:0]          stat_mispredicts
);

  localparam int unsigned PhtEntries = 2 ** PHT_IDX_W;
  localparam int unsigned BtbEntries = 2 ** BTB_IDX_W;
  localparam int unsigned TagW       = 32 - BTB_IDX_W - 2;

  logic [1:0]           pht_q   [PhtEntries];
  logic                 valid_q [BtbEntries];
  logic [TagW-1:0]      tag_q   [BtbEntries];
  logic [31:0]          tgt_q   [BtbEntries];
  logic [PHT_IDX_W-1:0] ghr_q;

  logic [PHT_IDX_W-1:0] lk_idx;
  logic [BTB_IDX_W-1:0] lk_set;
  logic [TagW-1:0]      lk_tag;
  logic [BTB_IDX_W-1:0] up_set;
  logic [TagW-1:0]      up_tag;
  logic [1:0]           pht_cur;
  logic [1:0]           pht_nxt;

  // Lookup: purely combinational, sees pre-update table and history state.
  always_comb begin
    lk_idx       = F_PC[PHT_IDX_W+1:2] ^ ghr_q;
    lk_set       = F_PC[BTB_IDX_W+1:2];
    lk_tag       = F_PC[31:BTB_IDX_W+2];
    F_pht_idx    = lk_idx;
    F_btb_hit    = valid_q[lk_set] && (tag_q[lk_set] == lk_tag);
    F_btb_target = F_btb_hit ? tgt_q[lk_set] : 32'h0;
    F_pred_taken = pht_q[lk_idx][1] & F_btb_hit;
    F_next_pc    = F_pred_taken ? F_btb_target : F_PC + 32'd4;
  end

  always_comb begin
    up_set  = ex_pc[BTB_IDX_W+1:2];
    up_tag  = ex_pc[31:BTB_IDX_W+2];
    pht_cur = pht_q[ex_pht_idx];
    pht_nxt = pht_cur;
    if (ex_actual_taken && pht_cur != 2'b11) begin
      pht_nxt = pht_cur + 2'b01;
    end else if (!ex_actual_taken && pht_cur != 2'b00) begin
      pht_nxt = pht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PhtEntries; i++) pht_q[i] <= 2'b01;
    end else if (ex_update_en) begin
      pht_q[ex_pht_idx] <= pht_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BtbEntries; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (ex_update_en && ex_actual_taken) begin
      valid_q[up_set] <= 1'b1;
      tag_q[up_set]   <= up_tag;
      tgt_q[up_set]   <= ex_actual_target;
    end
  end

  // History is non-speculative: shifts only on resolved updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (ex_update_en) begin
      ghr_q <= {ghr_q[PHT_IDX_W-2:0], ex_actual_taken};
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_mis_q;
  logic        unused_addr_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else if (ex_update_en) begin
      if (stat_upd_q != 32'hFFFF_FFFF) stat_upd_q <= stat_upd_q + 32'd1;
      if (redirect_valid && stat_mis_q != 32'hFFFF_FFFF) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mis_q;
  assign unused_addr_bits = ^{F_PC[1:0], ex_pc[1:0]};
`else
  logic unused_addr_bits;

  assign stat_updates     = 32'h0;
  assign stat_mispredicts = 32'h0;
  assign unused_addr_bits = ^{F_PC[1:0], ex_pc[1:0], redirect_valid};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, training, saturation, BTB aliasing,
// same-cycle read/write, asynchronous reset and statistics counters.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] F_PC = 32'h0;
  logic        F_pred_taken;
  logic [7:0]  F_pht_idx;
  logic        F_btb_hit;
  logic [31:0] F_btb_target;
  logic [31:0] F_next_pc;
  logic        ex_update_en = 1'b0;
  logic        ex_actual_taken = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic [31:0] ex_actual_target = 32'h0;
  logic [7:0]  ex_pht_idx = 8'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int failures = 0;

  branch_predictor #(.PHT_IDX_W(8), .BTB_IDX_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .F_PC             (F_PC),
    .F_pred_taken     (F_pred_taken),
    .F_pht_idx        (F_pht_idx),
    .F_btb_hit        (F_btb_hit),
    .F_btb_target     (F_btb_target),
    .F_next_pc        (F_next_pc),
    .ex_update_en     (ex_update_en),
    .ex_actual_taken  (ex_actual_taken),
    .ex_pc            (ex_pc),
    .ex_actual_target (ex_actual_target),
    .ex_pht_idx       (ex_pht_idx),
    .redirect_valid   (redirect_valid),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic [7:0] idx, input logic redir);
    ex_update_en     = 1'b1;
    ex_pc            = pc;
    ex_actual_taken  = tk;
    ex_actual_target = tgt;
    ex_pht_idx       = idx;
    redirect_valid   = redir;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ex_update_en   = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic [7:0] idx);
    drive_upd(pc, tk, tgt, idx, 1'b0);
    step();
  endtask

  task automatic do_reset();
    ex_update_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    F_PC = pc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    lookup(32'h100);
    checks++; if (F_pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred got %h want 0", F_pred_taken); end
    checks++; if (F_btb_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got %h want 0", F_btb_hit); end
    checks++; if (F_btb_target !== 32'h0) begin failures++; $display("FAIL rst_tgt got %h want 0", F_btb_target); end
    checks++; if (F_next_pc !== 32'h104) begin failures++; $display("FAIL rst_next got %h want 104", F_next_pc); end
    checks++; if (F_pht_idx !== 8'h40) begin failures++; $display("FAIL rst_idx got %h want 40", F_pht_idx); end
    lookup(32'hFFFF_FFFC);
    checks++; if (F_next_pc !== 32'h0) begin failures++; $display("FAIL wrap_next got %h want 0", F_next_pc); end
    checks++; if (F_pht_idx !== 8'hFF) begin failures++; $display("FAIL wrap_idx got %h want ff", F_pht_idx); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_train();
    do_reset();
    upd(32'h100, 1'b1, 32'h200, 8'h40);
    lookup(32'h100);
    checks++; if (F_pht_idx !== 8'h41) begin failures++; $display("FAIL tr1_idx got %h want 41", F_pht_idx); end
    checks++; if (F_btb_hit !== 1'b1) begin failures++; $display("FAIL tr1_hit got %h want 1", F_btb_hit); end
    checks++; if (F_btb_target !== 32'h200) begin failures++; $display("FAIL tr1_tgt got %h want 200", F_btb_target); end
    checks++; if (F_pred_taken !== 1'b0) begin failures++; $display("FAIL tr1_pred got %h want 0", F_pred_taken); end
    checks++; if (F_next_pc !== 32'h104) begin failures++; $display("FAIL tr1_next got %h want 104", F_next_pc); end
    upd(32'h100, 1'b1, 32'h200, 8'h41);
    lookup(32'h100);
    checks++; if (F_pht_idx !== 8'h43) begin failures++; $display("FAIL tr2_idx got %h want 43", F_pht_idx); end
    checks++; if (F_pred_taken !== 1'b0) begin failures++; $display("FAIL tr2_pred got %h want 0", F_pred_taken); end
    // Training shifts GHR to 0x0F, so PC 0x130 is the one that maps back onto idx 0x43.
    upd(32'h130, 1'b1, 32'h200, 8'h43);
    upd(32'h130, 1'b1, 32'h200, 8'h43);
    lookup(32'h130);
    checks++; if (F_pht_idx !== 8'h43) begin failures++; $display("FAIL tr3_idx got %h want 43", F_pht_idx); end
    checks++; if (F_pred_taken !== 1'b1) begin failures++; $display("FAIL tr3_pred got %h want 1", F_pred_taken); end
    checks++; if (F_next_pc !== 32'h200) begin failures++; $display("FAIL tr3_next got %h want 200", F_next_pc); end
  endtask

  task automatic test_saturation();
    logic [31:0] pcs [4];
    pcs[0] = 32'h3BC; pcs[1] = 32'h3B8; pcs[2] = 32'h380; pcs[3] = 32'h3C4;
    do_reset();
    // Eight taken updates install the lookup PCs in the BTB and drive GHR to 0xFF.
    for (int i = 0; i < 8; i++) upd(pcs[i % 4], 1'b1, 32'h800, 8'hF0);
    lookup(32'h3BC);
    checks++; if (F_pht_idx !== 8'h10) begin failures++; $display("FAIL sat0_idx got %h want 10", F_pht_idx); end
    checks++; if (F_pred_taken !== 1'b0) begin failures++; $display("FAIL sat0_pred got %h want 0", F_pred_taken); end
    for (int i = 0; i < 5; i++) upd(32'h3BC, 1'b1, 32'h800, 8'h10);
    lookup(32'h3BC);
    checks++; if (F_pred_taken !== 1'b1) begin failures++; $display("FAIL sat3_pred got %h want 1", F_pred_taken); end
    checks++; if (F_next_pc !== 32'h800) begin failures++; $display("FAIL sat3_next got %h want 800", F_next_pc); end
    upd(32'h3BC, 1'b0, 32'h0, 8'h10);
    lookup(32'h3B8);
    checks++; if (F_pht_idx !== 8'h10) begin failures++; $display("FAIL sat2_idx got %h want 10", F_pht_idx); end
    checks++; if (F_pred_taken !== 1'b1) begin failures++; $display("FAIL sat2_pred got %h want 1", F_pred_taken); end
    for (int i = 0; i < 3; i++) upd(32'h3BC, 1'b0, 32'h0, 8'h10);
    lookup(32'h380);
    checks++; if (F_btb_hit !== 1'b1) begin failures++; $display("FAIL sat0b_hit got %h want 1", F_btb_hit); end
    checks++; if (F_pred_taken !== 1'b0) begin failures++; $display("FAIL sat0b_pred got %h want 0", F_pred_taken); end
    upd(32'h380, 1'b1, 32'h800, 8'h10);
    lookup(32'h3C4);
    checks++; if (F_pht_idx !== 8'h10) begin failures++; $display("FAIL sat1_idx got %h want 10", F_pht_idx); end
    checks++; if (F_btb_hit !== 1'b1) begin failures++; $display("FAIL sat1_hit got %h want 1", F_btb_hit); end
    checks++; if (F_pred_taken !== 1'b0) begin failures++; $display("FAIL sat1_pred got %h want 0", F_pred_taken); end
  endtask

  task automatic test_btb_alias();
    do_reset();
    upd(32'h100, 1'b1, 32'h200, 8'h00);
    upd(32'h500, 1'b1, 32'h600, 8'h00);
    lookup(32'h100);
    checks++; if (F_btb_hit !== 1'b0) begin failures++; $display("FAIL alias_old_hit got %h want 0", F_btb_hit); end
    checks++; if (F_btb_target !== 32'h0) begin failures++; $display("FAIL alias_old_tgt got %h want 0", F_btb_target); end
    lookup(32'h500);
    checks++; if (F_btb_hit !== 1'b1) begin failures++; $display("FAIL alias_new_hit got %h want 1", F_btb_hit); end
    checks++; if (F_btb_target !== 32'h600) begin failures++; $display("FAIL alias_new_tgt got %h want 600", F_btb_target); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    upd(32'h100, 1'b1, 32'h200, 8'h50);
    // Lookup and update hit PHT idx 0x41 on the same edge.
    F_PC = 32'h100;
    drive_upd(32'h108, 1'b1, 32'h300, 8'h41, 1'b0);
    #1;
    checks++; if (F_pht_idx !== 8'h41) begin failures++; $display("FAIL same_idx got %h want 41", F_pht_idx); end
    checks++; if (F_pred_taken !== 1'b0) begin failures++; $display("FAIL same_pred_old got %h want 0", F_pred_taken); end
    step();
    checks++; if (F_pht_idx !== 8'h43) begin failures++; $display("FAIL same_ghr_new got %h want 43", F_pht_idx); end
    lookup(32'h108);
    checks++; if (F_pht_idx !== 8'h41) begin failures++; $display("FAIL same_idx2 got %h want 41", F_pht_idx); end
    checks++; if (F_pred_taken !== 1'b1) begin failures++; $display("FAIL same_pred_new got %h want 1", F_pred_taken); end
    checks++; if (F_next_pc !== 32'h300) begin failures++; $display("FAIL same_next_new got %h want 300", F_next_pc); end
    F_PC = 32'h700;
    drive_upd(32'h700, 1'b1, 32'h900, 8'h00, 1'b0);
    #1;
    checks++; if (F_btb_hit !== 1'b0) begin failures++; $display("FAIL same_btb_old got %h want 0", F_btb_hit); end
    checks++; if (F_next_pc !== 32'h704) begin failures++; $display("FAIL same_btb_oldnext got %h want 704", F_next_pc); end
    step();
    checks++; if (F_btb_hit !== 1'b1) begin failures++; $display("FAIL same_btb_new got %h want 1", F_btb_hit); end
    checks++; if (F_btb_target !== 32'h900) begin failures++; $display("FAIL same_btb_tgt got %h want 900", F_btb_target); end
    // Asynchronous reset mid-update, between clock edges.
    F_PC = 32'h108;
    drive_upd(32'h108, 1'b1, 32'h400, 8'h41, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (F_btb_hit !== 1'b0) begin failures++; $display("FAIL arst_hit got %h want 0", F_btb_hit); end
    checks++; if (F_btb_target !== 32'h0) begin failures++; $display("FAIL arst_tgt got %h want 0", F_btb_target); end
    checks++; if (F_pred_taken !== 1'b0) begin failures++; $display("FAIL arst_pred got %h want 0", F_pred_taken); end
    checks++; if (F_next_pc !== 32'h10C) begin failures++; $display("FAIL arst_next got %h want 10c", F_next_pc); end
    checks++; if (F_pht_idx !== 8'h42) begin failures++; $display("FAIL arst_idx got %h want 42", F_pht_idx); end
    @(posedge clk);
    #1;
    checks++; if (F_btb_hit !== 1'b0) begin failures++; $display("FAIL arst_hold_hit got %h want 0", F_btb_hit); end
    checks++; if (F_pht_idx !== 8'h42) begin failures++; $display("FAIL arst_hold_idx got %h want 42", F_pht_idx); end
    ex_update_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stats();
    logic [31:0] exp_upd;
    logic [31:0] exp_mis;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_upd(32'h40, 1'b0, 32'h0, 8'h00, (i == 1 || i == 4 || i == 8));
      step();
    end
`ifdef BP_STATS_EN
    exp_upd = 32'd10;
    exp_mis = 32'd3;
`else
    exp_upd = 32'd0;
    exp_mis = 32'd0;
`endif
    checks++; if (stat_updates !== exp_upd) begin failures++; $display("FAIL stat_upd got %0d want %0d", stat_updates, exp_upd); end
    checks++; if (stat_mispredicts !== exp_mis) begin failures++; $display("FAIL stat_mis got %0d want %0d", stat_mispredicts, exp_mis); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturation();
    test_btb_alias();
    test_back_to_back();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
